// File: rtl/boot_rom_ctrl_if.sv
// Bus bundle between the CPU address decoder (master) and the boot ROM (slave).
interface boot_rom_ctrl_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
);
   logic              rd_en;
   logic [ADDR_W-1:0] address;
   logic              sel_firmware;
   logic              sel_vectors;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              vec_wr_en;
   logic [2:0]        vec_wr_idx;
   logic [DATA_W-1:0] vec_wr_data;
   logic              vec_lock;
   logic              vec_locked;
   logic              vec_wr_err;

   modport master (
      output rd_en, address, sel_firmware, sel_vectors,
             vec_wr_en, vec_wr_idx, vec_wr_data, vec_lock,
      input  data_out, data_valid, vec_locked, vec_wr_err
   );

   modport slave (
      input  rd_en, address, sel_firmware, sel_vectors,
             vec_wr_en, vec_wr_idx, vec_wr_data, vec_lock,
      output data_out, data_valid, vec_locked, vec_wr_err
   );
endinterface

// File: rtl/boot_rom_ctrl.sv
// Firmware + interrupt-vector ROM with registered, READ_LAT-deep read pipeline
// and a lockable shadow register file that overrides individual vector bytes.
// ROM images are elaboration-time constants (FW_IMAGE byte i at bits
// [i*DATA_W +: DATA_W], likewise VEC_INIT), so contents map straight onto
// a constant ROM / initialised block RAM without simulation-only loaders.
module boot_rom_ctrl #(
   parameter int DATA_W     = 8,
   parameter int FW_SIZE    = 'h3000,
   parameter int NUM_VEC    = 6,
   parameter int VEC_OFFSET = 2,
   parameter int READ_LAT   = 1,
   parameter logic [FW_SIZE*DATA_W-1:0] FW_IMAGE = '0,
   // Default vectors, index 0 in the low byte: NMI lo/hi, RST lo/hi, IRQ lo/hi
   parameter logic [NUM_VEC*DATA_W-1:0] VEC_INIT = 48'hE0_00_C0_00_80_00
) (
   input  logic clk,
   input  logic rst_n,
   boot_rom_ctrl_if.slave bus
);
   localparam int ADDR_W = $clog2(FW_SIZE);

   // Vector space is addressed with 3 bits; pad the default image to 8 entries
   localparam logic [8*DATA_W-1:0] VEC_ROM = (8*DATA_W)'(VEC_INIT);

   logic [DATA_W-1:0] shadow [8];
   logic [7:0]        override;
   logic              locked;
   logic              wr_err;

   logic              accept;
   logic              wr_ok;
   logic [2:0]        vi;
   logic [DATA_W-1:0] rd_byte;

   logic [READ_LAT:1]             vld_pipe;
   logic [READ_LAT:1][DATA_W-1:0] data_pipe;

   assign accept = bus.rd_en & (bus.sel_firmware | bus.sel_vectors);
   assign wr_ok  = bus.vec_wr_en & ~locked & (int'(bus.vec_wr_idx) < NUM_VEC);
   assign vi     = bus.address[2:0] - 3'(VEC_OFFSET);

   // Select the byte for this request; firmware wins when both selects are set,
   // out-of-range firmware or vector indices read as zero.
   always_comb begin
      rd_byte = '0;
      if (bus.sel_firmware) begin
         if (int'(bus.address) < FW_SIZE)
            rd_byte = FW_IMAGE[int'(bus.address)*DATA_W +: DATA_W];
      end else if (int'(vi) < NUM_VEC) begin
         rd_byte = override[vi] ? shadow[vi] : VEC_ROM[int'(vi)*DATA_W +: DATA_W];
      end
   end

   // Read pipeline: stage 1 samples the (pre-write) byte, later stages just delay it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
      end else begin
         vld_pipe[1] <= accept;
         if (accept)
            data_pipe[1] <= rd_byte;
         for (int k = 2; k <= READ_LAT; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            data_pipe[k] <= data_pipe[k-1];
         end
      end
   end

   // Override bits, sticky lock and the one-cycle write-reject pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         override <= '0;
         locked   <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         if (wr_ok)
            override[bus.vec_wr_idx] <= 1'b1;
         if (bus.vec_lock)
            locked <= 1'b1;
         wr_err <= bus.vec_wr_en & ~wr_ok;
      end
   end

   // Shadow bytes hold no reset; they only matter once their override bit is set
   always_ff @(posedge clk) begin
      if (wr_ok)
         shadow[bus.vec_wr_idx] <= bus.vec_wr_data;
   end

   assign bus.data_valid = vld_pipe[READ_LAT];
   assign bus.data_out   = vld_pipe[READ_LAT] ? data_pipe[READ_LAT] : '0;
   assign bus.vec_locked = locked;
   assign bus.vec_wr_err = wr_err;

   logic unused_addr_w;
   assign unused_addr_w = (ADDR_W == 0);
endmodule

// File: tb/tb_boot_rom_ctrl.sv
// Directed bench: one READ_LAT=1 and one READ_LAT=2 instance driven in lockstep,
// expected read bytes queued at request time and popped when data_valid fires.
module tb_boot_rom_ctrl;
   localparam int FW_SIZE = 'h3000;
   localparam int AW      = $clog2(FW_SIZE);
   // fw[0..3] = A9 1F 2E 3D, fw[0x2FFF] = 5A, everything else 0
   localparam logic [FW_SIZE*8-1:0] FW_IMG =
      {8'h5A, {((FW_SIZE-5)*8){1'b0}}, 8'h3D, 8'h2E, 8'h1F, 8'hA9};
   localparam logic [47:0] VEC_IMG = 48'hE0_00_C0_00_80_00;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   boot_rom_ctrl_if #(.ADDR_W(AW), .DATA_W(8)) b1 ();
   boot_rom_ctrl_if #(.ADDR_W(AW), .DATA_W(8)) b2 ();

   boot_rom_ctrl #(.DATA_W(8), .FW_SIZE(FW_SIZE), .NUM_VEC(6), .VEC_OFFSET(2),
                   .READ_LAT(1), .FW_IMAGE(FW_IMG), .VEC_INIT(VEC_IMG))
      u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   boot_rom_ctrl #(.DATA_W(8), .FW_SIZE(FW_SIZE), .NUM_VEC(6), .VEC_OFFSET(2),
                   .READ_LAT(2), .FW_IMAGE(FW_IMG), .VEC_INIT(VEC_IMG))
      u_lat2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] q1 [$];
   logic [7:0] q2 [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare each valid beat against the oldest queued byte
   always @(negedge clk) begin
      if (b1.data_valid) begin
         if (q1.size() == 0) chk("lat1_valid_without_request", b1.data_valid, 1'b0);
         else chk("lat1_read_data", b1.data_out, q1.pop_front());
      end else chk("lat1_idle_data_zero", b1.data_out, 8'h00);
   end

   always @(negedge clk) begin
      if (b2.data_valid) begin
         if (q2.size() == 0) chk("lat2_valid_without_request", b2.data_valid, 1'b0);
         else chk("lat2_read_data", b2.data_out, q2.pop_front());
      end else chk("lat2_idle_data_zero", b2.data_out, 8'h00);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic rd, input logic fw, input logic vec, input logic [AW-1:0] a);
      b1.rd_en = rd; b1.sel_firmware = fw; b1.sel_vectors = vec; b1.address = a;
      b2.rd_en = rd; b2.sel_firmware = fw; b2.sel_vectors = vec; b2.address = a;
   endtask

   task automatic set_wr(input logic en, input logic [2:0] idx, input logic [7:0] d, input logic lk);
      b1.vec_wr_en = en; b1.vec_wr_idx = idx; b1.vec_wr_data = d; b1.vec_lock = lk;
      b2.vec_wr_en = en; b2.vec_wr_idx = idx; b2.vec_wr_data = d; b2.vec_lock = lk;
   endtask

   task automatic req(input logic fw, input logic vec, input logic [AW-1:0] a, input logic [7:0] exp);
      set_rd(1'b1, fw, vec, a);
      q1.push_back(exp);
      q2.push_back(exp);
      tick();
   endtask

   task automatic idle(input int n);
      set_rd(1'b0, 1'b0, 1'b0, '0);
      repeat (n) tick();
   endtask

   task automatic chk_err(input string tag, input logic exp);
      chk({tag, "_lat1"}, b1.vec_wr_err, exp);
      chk({tag, "_lat2"}, b2.vec_wr_err, exp);
   endtask

   initial begin
      set_rd(1'b0, 1'b0, 1'b0, '0);
      set_wr(1'b0, 3'd0, 8'h00, 1'b0);
      #1 rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_valid_lat1", b1.data_valid, 1'b0);
      chk("reset_valid_lat2", b2.data_valid, 1'b0);
      chk("reset_locked_lat1", b1.vec_locked, 1'b0);
      chk("reset_locked_lat2", b2.vec_locked, 1'b0);
      chk_err("reset_wr_err", 1'b0);
      rst_n = 1'b1;
      idle(2);

      // Firmware reads, back-to-back, with explicit latency checks
      req(1'b1, 1'b0, 14'h0000, 8'hA9);
      chk("lat1_valid_after_1", b1.data_valid, 1'b1);
      chk("lat1_data_after_1", b1.data_out, 8'hA9);
      chk("lat2_not_valid_after_1", b2.data_valid, 1'b0);
      req(1'b1, 1'b0, 14'h0001, 8'h1F);
      chk("lat2_valid_after_2", b2.data_valid, 1'b1);
      chk("lat2_data_after_2", b2.data_out, 8'hA9);
      req(1'b1, 1'b0, 14'h0002, 8'h2E);
      req(1'b1, 1'b0, 14'h0003, 8'h3D);
      req(1'b1, 1'b0, 14'h2FFF, 8'h5A);
      req(1'b1, 1'b0, 14'h3000, 8'h00);
      req(1'b1, 1'b0, 14'h3FFF, 8'h00);
      req(1'b1, 1'b1, 14'h0002, 8'h2E);
      idle(3);

      // Requests that must not be accepted
      set_rd(1'b1, 1'b0, 1'b0, 14'h0000); tick();
      set_rd(1'b0, 1'b1, 1'b1, 14'h0005); tick();
      idle(3);

      // Default vectors through the offset mapping
      req(1'b0, 1'b1, 14'h0004, 8'h00);
      req(1'b0, 1'b1, 14'h0005, 8'hC0);
      req(1'b0, 1'b1, 14'h0002, 8'h00);
      req(1'b0, 1'b1, 14'h0003, 8'h80);
      req(1'b0, 1'b1, 14'h0006, 8'h00);
      req(1'b0, 1'b1, 14'h0007, 8'hE0);
      req(1'b0, 1'b1, 14'h0000, 8'h00);
      req(1'b0, 1'b1, 14'h0001, 8'h00);
      req(1'b0, 1'b1, 14'h1235, 8'hC0);
      idle(3);

      // Shadow override of RST hi
      set_wr(1'b1, 3'd3, 8'hD0, 1'b0); tick();
      set_wr(1'b0, 3'd0, 8'h00, 1'b0);
      chk_err("good_write_no_err", 1'b0);
      req(1'b0, 1'b1, 14'h0005, 8'hD0);

      // Same-cycle write and read of IRQ hi returns the old byte
      set_wr(1'b1, 3'd5, 8'h77, 1'b0);
      req(1'b0, 1'b1, 14'h0007, 8'hE0);
      set_wr(1'b0, 3'd0, 8'h00, 1'b0);
      req(1'b0, 1'b1, 14'h0007, 8'h77);
      idle(1);

      // Out-of-range index rejected with a single-cycle pulse
      set_wr(1'b1, 3'd6, 8'hAA, 1'b0); tick();
      set_wr(1'b0, 3'd0, 8'h00, 1'b0);
      chk_err("bad_idx_err", 1'b1);
      tick();
      chk_err("bad_idx_err_drops", 1'b0);

      // Lock in the same cycle as a write: the write still lands
      set_wr(1'b1, 3'd1, 8'h55, 1'b1); tick();
      set_wr(1'b0, 3'd0, 8'h00, 1'b0);
      chk("locked_lat1", b1.vec_locked, 1'b1);
      chk("locked_lat2", b2.vec_locked, 1'b1);
      chk_err("lock_write_no_err", 1'b0);
      req(1'b0, 1'b1, 14'h0003, 8'h55);
      idle(1);

      // Write while locked is rejected and leaves the shadow alone
      set_wr(1'b1, 3'd3, 8'h11, 1'b0); tick();
      set_wr(1'b0, 3'd0, 8'h00, 1'b0);
      chk_err("locked_write_err", 1'b1);
      tick();
      chk_err("locked_write_err_drops", 1'b0);
      req(1'b0, 1'b1, 14'h0005, 8'hD0);
      idle(3);

      // Reset with reads in flight: nothing comes out, overrides and lock cleared
      set_rd(1'b1, 1'b1, 1'b0, 14'h0000); tick();
      set_rd(1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_valid_lat1", b1.data_valid, 1'b0);
      chk("mid_reset_valid_lat2", b2.data_valid, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      idle(4);
      chk("post_reset_unlocked_lat1", b1.vec_locked, 1'b0);
      chk("post_reset_unlocked_lat2", b2.vec_locked, 1'b0);
      req(1'b0, 1'b1, 14'h0005, 8'hC0);
      req(1'b0, 1'b1, 14'h0007, 8'hE0);
      req(1'b0, 1'b1, 14'h0003, 8'h80);
      idle(4);

      chk("lat1_pending_reads", q1.size(), 0);
      chk("lat2_pending_reads", q2.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
